// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and imem geometry.
package imem_loader_pkg;

  localparam int unsigned IMEM_WORDS = 1024;
  localparam int unsigned ADDR_SHIFT = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/imem_loader.sv
// Streams a valid/ready word sequence into the instruction memory from address 0 and holds
// the CPU in reset until the image is complete. Define LOADER_CHECKSUM_EN for a trailing checksum word.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned CNT_W  = 11,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e            state_q;
  logic [CNT_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_we_q;
  logic [31:0]       mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              cpu_reset_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;

  logic              hs;
  logic              last_word;
  logic [31:0]       addr_d;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
`endif

  assign s_ready   = (state_q == LOAD) || (state_q == CHECK);
  assign hs        = s_valid && s_ready;
  assign last_word = (ptr_q == cnt_q - CNT_W'(1));
  assign addr_d    = 32'(ptr_q) << ADDR_SHIFT;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              cpu_reset_q <= 1'b0;
              error_q     <= 1'b0;
            end else if (32'(word_count) > IMEM_WORDS) begin
              error_q <= 1'b1;
            end else begin
              state_q     <= LOAD;
              cnt_q       <= word_count;
              ptr_q       <= '0;
              error_q     <= 1'b0;
              cpu_reset_q <= 1'b1;
              busy_q      <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
              sum_q       <= '0;
`endif
            end
          end
        end
        LOAD: begin
          if (hs) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= s_data;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_q + s_data;
`endif
            // ptr parks on count-1 so the address can never run past the image
            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
              state_q     <= CHECK;
`else
              state_q     <= DONE;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              cpu_reset_q <= 1'b0;
`endif
            end else begin
              ptr_q <= ptr_q + CNT_W'(1);
            end
          end
        end
        CHECK: begin
`ifdef LOADER_CHECKSUM_EN
          if (hs) begin
            if (s_data == sum_q) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
`else
          state_q <= IDLE;
`endif
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
